// File: rtl/instr_exec_unit.sv
// ---------------------------------------------------------------------------
// instr_exec_unit
//   Responder side of the sequencer->datapath instruction interface. It accepts
//   one 16-bit instruction per valid/ready handshake. The instruction runs on a
//   16 x DATA_W register file and a small ALU. The result is committed, then
//   returned with the flag register. The flag register is packed {C,L,F,Z,N}.
//
//   Ports
//     clk          single clock; all state updates on posedge
//     reset        synchronous, active-high
//     instr        {op[15:12], rdest[11:8], ext[7:4], rsrc[3:0]}; imm8 = [7:0]
//     instr_valid  sequencer presents instr
//     instr_ready  high only while idle
//     resp_valid   result committed; held until resp_ready
//     resp_ready   sequencer consumes the response
//     result       ALU result of the executed instruction (CMP: a-b)
//     flags        {C,L,F,Z,N} after the instruction
//     illegal      qualifies resp_valid: opcode unsupported, no state changed
//     dbg_addr     debug register select
//     dbg_data     reg[dbg_addr], registered (one cycle latency)
// ---------------------------------------------------------------------------
module instr_exec_unit #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        flags,
  output logic              illegal,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  // Function codes. They are shared by the register form (op==0, code in ext)
  // and the immediate form (code in op).
  localparam logic [3:0] FN_ADD = 4'b0101;
  localparam logic [3:0] FN_SUB = 4'b1001;
  localparam logic [3:0] FN_CMP = 4'b1011;
  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_OR  = 4'b0010;
  localparam logic [3:0] FN_XOR = 4'b0011;
  localparam logic [3:0] FN_MOV = 4'b1101;

  // Bit positions inside the flag register {C,L,F,Z,N}.
  localparam int FL_C = 4;
  localparam int FL_L = 3;
  localparam int FL_F = 2;
  localparam int FL_Z = 1;
  localparam int FL_N = 0;

  logic [1:0]        state_reg;
  logic [15:0]       instr_reg;
  logic [DATA_W-1:0] result_reg;
  logic [4:0]        flags_reg;
  logic              illegal_reg;
  logic [DATA_W-1:0] dbg_data_reg;
  logic [DATA_W-1:0] regs_reg [NREGS];

  // Decode fields of the latched instruction.
  logic [3:0]        op;
  logic [3:0]        rd;
  logic [3:0]        rs;
  logic              reg_form;
  logic [3:0]        fn;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign op       = instr_reg[15:12];
  assign rd       = instr_reg[11:8];
  assign rs       = instr_reg[3:0];
  assign reg_form = (op == 4'b0000);
  assign fn       = reg_form ? instr_reg[7:4] : op;
  assign imm_sext = {{(DATA_W-8){instr_reg[7]}}, instr_reg[7:0]};
  assign imm_zext = {{(DATA_W-8){1'b0}}, instr_reg[7:0]};

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_res_next;
  logic [4:0]        flags_next;
  logic              wr_en_next;
  logic              legal_next;

  // The register file is read combinationally during EXEC. Because of this,
  // rdest==rsrc sees the pre-write value.
  assign op_a = regs_reg[rd];
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  // diff[DATA_W] is the unsigned borrow (a < b).
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    if (reg_form) begin
      op_b = regs_reg[rs];
    end else if (op == FN_ADD || op == FN_SUB || op == FN_CMP) begin
      op_b = imm_sext;
    end else begin
      op_b = imm_zext;
    end
  end

  always_comb begin
    alu_res_next = '0;
    flags_next   = flags_reg;
    wr_en_next   = 1'b0;
    legal_next   = 1'b1;
    unique case (fn)
      FN_ADD: begin
        alu_res_next     = sum[DATA_W-1:0];
        wr_en_next       = 1'b1;
        flags_next[FL_C] = sum[DATA_W];
        flags_next[FL_F] = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                           (sum[DATA_W-1] != op_a[DATA_W-1]);
        flags_next[FL_Z] = (sum[DATA_W-1:0] == '0);
        flags_next[FL_N] = sum[DATA_W-1];
      end
      FN_SUB: begin
        alu_res_next     = diff[DATA_W-1:0];
        wr_en_next       = 1'b1;
        flags_next[FL_C] = diff[DATA_W];
        flags_next[FL_F] = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                           (diff[DATA_W-1] != op_a[DATA_W-1]);
        flags_next[FL_Z] = (diff[DATA_W-1:0] == '0);
        flags_next[FL_N] = diff[DATA_W-1];
      end
      FN_CMP: begin
        // Compare reports a-b but never writes the register file.
        // N is redefined as "signed less-than".
        alu_res_next     = diff[DATA_W-1:0];
        flags_next[FL_L] = diff[DATA_W];
        flags_next[FL_N] = ($signed(op_a) < $signed(op_b));
        flags_next[FL_Z] = (op_a == op_b);
      end
      FN_AND: begin
        alu_res_next = op_a & op_b;
        wr_en_next   = 1'b1;
      end
      FN_OR: begin
        alu_res_next = op_a | op_b;
        wr_en_next   = 1'b1;
      end
      FN_XOR: begin
        alu_res_next = op_a ^ op_b;
        wr_en_next   = 1'b1;
      end
      FN_MOV: begin
        alu_res_next = op_b;
        wr_en_next   = 1'b1;
      end
      default: begin
        legal_next = 1'b0;
      end
    endcase
  end

  // Per-register write strobes. These are only live on the EXEC->WB edge.
  logic [NREGS-1:0] wr_sel;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr_sel
    assign wr_sel[gi] = (state_reg == ST_EXEC) && wr_en_next && (rd == 4'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      instr_reg    <= '0;
      result_reg   <= '0;
      flags_reg    <= '0;
      illegal_reg  <= 1'b0;
      dbg_data_reg <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      // A write on this same edge becomes visible only on the next sample.
      dbg_data_reg <= regs_reg[dbg_addr];

      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i]) begin
          regs_reg[i] <= alu_res_next;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_reg <= instr;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // For an illegal op: the result is 0 and flags_next equals flags_reg,
          // so nothing architectural changes.
          result_reg  <= alu_res_next;
          flags_reg   <= flags_next;
          illegal_reg <= ~legal_next;
          state_reg   <= ST_WB;
        end
        ST_WB: begin
          if (resp_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_reg == ST_IDLE);
  assign resp_valid  = (state_reg == ST_WB);
  assign result      = result_reg;
  assign flags       = flags_reg;
  assign illegal     = illegal_reg;
  assign dbg_data    = dbg_data_reg;

endmodule

// File: tb/tb_instr_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_exec_unit
//   Directed bench for instr_exec_unit. Expected values are hand-computed
//   constants plus a tiny Fibonacci / doubling model built inside the bench.
// ---------------------------------------------------------------------------
module tb_instr_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  instr_exec_unit #(.DATA_W(16), .NREGS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .result      (result),
    .flags       (flags),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one instruction with resp_ready held high, then check the 2-edge latency.
  // The response fields are sampled while resp_valid is high.
  task automatic do_op(input logic [15:0] ins, output logic [15:0] res,
                       output logic [4:0] flg, output logic ill);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check_val("latency", n, 1);
    res = result;
    flg = flags;
    ill = illegal;
    $display("op %h -> result %h flags %b illegal %b", ins, res, flg, ill);
    @(posedge clk); #1;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
    dbg_addr = a;
    @(posedge clk); #1;
    v = dbg_data;
    $display("dbg R%0d = %h", a, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic [4:0]  f;
    logic        il;
    logic [15:0] v;
    logic [15:0] fib [15];
    logic [15:0] model;

    reset = 1'b1; instr = '0; instr_valid = 1'b0; resp_ready = 1'b1; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_instr_ready", instr_ready, 1);
    check_val("rst_result", result, 0);
    check_val("rst_flags", flags, 0);
    check_val("rst_illegal", illegal, 0);
    check_val("rst_dbg", dbg_data, 0);

    // Test 1: MOVI R0,1
    do_op(16'hD001, r, f, il);
    check_val("movi_result", r, 16'h0001);
    check_val("movi_flags", f, 5'b00000);
    check_val("movi_illegal", il, 0);
    read_reg(4'd0, v);
    check_val("movi_r0", v, 16'h0001);

    // Test 2: Fibonacci chain R2..R14 via MOV Rk,Rk-1 ; ADD Rk,Rk-2
    do_op(16'hD101, r, f, il);
    fib[0] = 16'd1;
    fib[1] = 16'd1;
    for (int k = 2; k < 15; k++) begin
      fib[k] = fib[k-1] + fib[k-2];
      do_op({4'h0, 4'(k), 4'hD, 4'(k-1)}, r, f, il);
      check_val($sformatf("fib_mov%0d", k), r, fib[k-1]);
      do_op({4'h0, 4'(k), 4'h5, 4'(k-2)}, r, f, il);
      check_val($sformatf("fib_add%0d", k), r, fib[k]);
      check_val($sformatf("fib_flags%0d", k), f, 5'b00000);
    end
    read_reg(4'd14, v);
    check_val("fib_r14", v, 16'h0262);

    // Test 3: build 0x8000 by doubling, then 0x7FFF + 1 overflow
    do_op(16'hD380, r, f, il);
    model = 16'h0080;
    for (int k = 0; k < 8; k++) begin
      model = model + model;
      do_op(16'h0353, r, f, il);
      check_val("dbl_result", r, model);
    end
    do_op(16'h9301, r, f, il);
    check_val("subi_7fff", r, 16'h7FFF);
    check_val("subi_7fff_flags", f, 5'b00100);
    do_op(16'h5301, r, f, il);
    check_val("addi_ovf_result", r, 16'h8000);
    check_val("addi_ovf_flags", f, 5'b00101);
    do_op(16'hD300, r, f, il);
    check_val("movi_keeps_flags", f, 5'b00101);
    do_op(16'h9301, r, f, il);
    check_val("subi_borrow_result", r, 16'hFFFF);
    check_val("subi_borrow_flags", f, 5'b10001);
    do_op(16'h53FF, r, f, il);
    check_val("addi_carry_result", r, 16'hFFFE);
    check_val("addi_carry_flags", f, 5'b10001);
    do_op(16'h0393, r, f, il);
    check_val("sub_self_result", r, 16'h0000);
    check_val("sub_self_flags", f, 5'b00010);

    // Test 4: CMP R4=5 vs R5=0xFFFF
    do_op(16'hD405, r, f, il);
    do_op(16'hD500, r, f, il);
    do_op(16'h9501, r, f, il);
    check_val("r5_ffff_flags", f, 5'b10001);
    do_op(16'h04B5, r, f, il);
    check_val("cmp_result", r, 16'h0006);
    check_val("cmp_flags", f, 5'b11000);
    read_reg(4'd4, v);
    check_val("cmp_r4", v, 16'h0005);
    read_reg(4'd5, v);
    check_val("cmp_r5", v, 16'hFFFF);
    do_op(16'hB405, r, f, il);
    check_val("cmpi_eq_result", r, 16'h0000);
    check_val("cmpi_eq_flags", f, 5'b10010);

    // Test 5: back-pressure on the response
    resp_ready  = 1'b0;
    instr       = 16'hD65A;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 16'hD6FF;
    @(posedge clk); #1;
    check_val("bp_resp_valid", resp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("bp_hold_valid%0d", k), resp_valid, 1);
      check_val($sformatf("bp_hold_result%0d", k), result, 16'h005A);
      check_val($sformatf("bp_instr_ready%0d", k), instr_ready, 0);
    end
    $display("op d65a held 5 clk -> result %h", result);
    instr_valid = 1'b0;
    resp_ready  = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_valid", resp_valid, 0);
    check_val("bp_release_ready", instr_ready, 1);
    read_reg(4'd6, v);
    check_val("bp_r6", v, 16'h005A);

    // Test 6: illegal ops, logic ops, reset during EXEC
    do_op(16'hF123, r, f, il);
    check_val("ill_flag", il, 1);
    check_val("ill_result", r, 16'h0000);
    check_val("ill_flags", f, 5'b10010);
    read_reg(4'd1, v);
    check_val("ill_r1", v, 16'h0001);
    do_op(16'h0171, r, f, il);
    check_val("ill_ext_flag", il, 1);
    do_op(16'h11FF, r, f, il);
    check_val("andi_result", r, 16'h0001);
    check_val("andi_illegal", il, 0);
    check_val("andi_flags", f, 5'b10010);
    do_op(16'h2110, r, f, il);
    check_val("ori_result", r, 16'h0011);
    do_op(16'h0131, r, f, il);
    check_val("xor_self_result", r, 16'h0000);

    instr       = 16'hD7AB;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check_val("pre_rst_exec", instr_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("op d7ab aborted by reset in EXEC");
    check_val("midrst_resp_valid", resp_valid, 0);
    check_val("midrst_instr_ready", instr_ready, 1);
    check_val("midrst_flags", flags, 0);
    check_val("midrst_result", result, 0);
    read_reg(4'd7, v);
    check_val("midrst_r7", v, 16'h0000);
    @(posedge clk); #1;
    check_val("midrst_stay_idle", resp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
